// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// The cache FSM has two states: IDLE (accepting requests) and MISS (refill running).
package icache_pkg;

    localparam int ICACHE_INDEX_WIDTH = 5;
    localparam int WORD_W             = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } icache_state_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side bundles of the instruction cache.
// Handshake: if_req is taken on a cycle where if_ready=1 and rdy=1; the answer is a one-cycle
// if_valid pulse. fet_ena stays high until valid_2icache=1 completes the refill; there is no abort.
interface icache_fetch_if;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_clear;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;

    modport master (output if_req, if_pc, if_clear, input  if_ready, if_valid, if_instr);
    modport slave  (input  if_req, if_pc, if_clear, output if_ready, if_valid, if_instr);
endinterface

interface icache_mem_if;
    logic        fet_ena;
    logic [31:0] instr_addr;
    logic        valid_2icache;
    logic [31:0] data_2icache;

    modport master (output fet_ena, instr_addr, input  valid_2icache, data_2icache);
    modport slave  (input  fet_ena, instr_addr, output valid_2icache, data_2icache);
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line. Hits answer in one cycle;
// misses request the line from the memory controller and forward the returned word.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    icache_fetch_if.slave  fetch,
    icache_mem_if.master   mem,
    output icache_state_e  dbg_state
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH - 2;

    icache_state_e state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic             drop_q;
    logic             if_valid_q;
    logic [31:0]      if_instr_q;
    logic             fet_ena_q;
    logic [31:0]      instr_addr_q;

    logic [INDEX_WIDTH-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0]       req_tag, miss_tag;
    logic                   accept, hit, refill_done;

    assign req_idx  = fetch.if_pc[INDEX_WIDTH+1:2];
    assign req_tag  = fetch.if_pc[31:INDEX_WIDTH+2];
    // The registered miss address doubles as the latched pc for the refill write.
    assign miss_idx = instr_addr_q[INDEX_WIDTH+1:2];
    assign miss_tag = instr_addr_q[31:INDEX_WIDTH+2];

    assign accept      = rdy && (state_q == ST_IDLE) && fetch.if_req && !fetch.if_clear;
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign refill_done = rdy && (state_q == ST_MISS) && mem.valid_2icache;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                ST_IDLE: if (accept && !hit)     state_d = ST_MISS;
                ST_MISS: if (mem.valid_2icache)  state_d = ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays are deliberately left out of reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mem.data_2icache;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            drop_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            fet_ena_q    <= 1'b0;
            instr_addr_q <= '0;
        end else if (rdy) begin
            if_valid_q <= 1'b0;
            if (accept) begin
                if (hit) begin
                    if_valid_q <= 1'b1;
                    if_instr_q <= data_mem[req_idx];
                end else begin
                    fet_ena_q    <= 1'b1;
                    instr_addr_q <= word_align(fetch.if_pc);
                end
            end
            if (state_q == ST_MISS) begin
                if (fetch.if_clear) drop_q <= 1'b1;
                if (mem.valid_2icache) begin
                    valid_q[miss_idx] <= 1'b1;
                    fet_ena_q         <= 1'b0;
                    drop_q            <= 1'b0;
                    if (!drop_q && !fetch.if_clear) begin
                        if_valid_q <= 1'b1;
                        if_instr_q <= mem.data_2icache;
                    end
                end
            end
        end
    end

    // A flush in the response cycle of a hit suppresses that response.
    assign fetch.if_ready = (state_q == ST_IDLE);
    assign fetch.if_valid = if_valid_q && !fetch.if_clear;
    assign fetch.if_instr = if_instr_q;
    assign mem.fet_ena    = fet_ena_q;
    assign mem.instr_addr = instr_addr_q;
    assign dbg_state      = state_q;

endmodule
